ne_rx_ring: RTL

NE_RX_RING -- requirements
Module: ne_rx_ring

---
 rtl/ne2000_pkg.sv | 26 ++
 rtl/ne_sync_edge.sv | 26 ++
 rtl/ne_rx_ring.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ne2000_pkg.sv
// Shared NE2000 receive-ring definitions: FSM states, header constants and the
// ring page-advance helper used by both the write and the remote-DMA read side.
package ne2000_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_HDR  = 2'd2,
        ST_DROP = 2'd3
    } rx_state_e;

    localparam logic [7:0] HDR_STATUS_OK = 8'h01;
    localparam int         PAGE_SIZE     = 256;
    localparam int         MIN_FRAME     = 60;

    // Page after 'page'; reaching pstop folds back to pstart.
    function automatic logic [7:0] ring_next_page(input logic [7:0] page,
                                                  input logic [7:0] pstart,
                                                  input logic [7:0] pstop);
        logic [7:0] nxt;
        nxt = page + 8'd1;
        if (nxt == pstop) nxt = pstart;
        return nxt;
    endfunction

endpackage

// File: rtl/ne_sync_edge.sv
// Three-flop synchroniser for an asynchronous level, with rise/fall pulses
// derived from the last two synchronised samples.
module ne_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], async_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign rise_o = sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/ne_rx_ring.sv
// NE2000-style receive ring: writes frames into paged RAM with a 4-byte header
// and serves remote-DMA byte reads. Define NE_RX_RUNT_FILTER_EN to drop runts.
module ne_rx_ring
    import ne2000_pkg::*;
#(
    parameter int         RING_PAGES = 32,
    parameter logic [7:0] PAGE_BASE  = 8'h40,
    parameter int         MAX_FRAME  = 1536
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  pstart,
    input  logic [7:0]  pstop,
    input  logic [7:0]  bnry,
    input  logic        curr_we,
    input  logic [7:0]  curr_din,
    output logic [7:0]  curr,
    input  logic        rx_begin,
    input  logic        rx_strobe,
    input  logic [7:0]  rx_byte,
    input  logic        dma_start,
    input  logic [15:0] rsar,
    input  logic [15:0] rbcr,
    input  logic        dma_rd,
    output logic [7:0]  dma_data,
    output logic        irq_prx,
    output logic        irq_ovw,
    output logic        irq_rdc,
    output logic        busy
);

    localparam int          PW      = (RING_PAGES > 1) ? $clog2(RING_PAGES) : 1;
    localparam int          AW      = PW + 8;
    localparam int          DEPTH   = RING_PAGES * PAGE_SIZE;
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME);

    // Out-of-range pages alias back into the ring by modulo on the page index.
    function automatic logic [AW-1:0] ram_addr(input logic [15:0] a);
        logic [7:0] rel;
        rel = a[15:8] - PAGE_BASE;
        return {PW'(32'(rel) % RING_PAGES), a[7:0]};
    endfunction

    logic begin_rise, begin_fall, strobe_rise, strobe_fall_unused;

    ne_sync_edge u_sync_begin (
        .clk     (clk),
        .rst_n   (reset_n),
        .async_i (rx_begin),
        .rise_o  (begin_rise),
        .fall_o  (begin_fall)
    );

    ne_sync_edge u_sync_strobe (
        .clk     (clk),
        .rst_n   (reset_n),
        .async_i (rx_strobe),
        .rise_o  (strobe_rise),
        .fall_o  (strobe_fall_unused)
    );

    logic [7:0] mem [DEPTH];

    rx_state_e   state_q, state_d;
    logic [7:0]  curr_q, curr_d;
    logic [7:0]  start_q, start_d;
    logic [7:0]  next_q, next_d;
    logic [15:0] wr_ptr_q, wr_ptr_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  hdr_idx_q, hdr_idx_d;
    logic [15:0] rd_ptr_q, rd_ptr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  dma_data_q, dma_data_d;
    logic        irq_prx_q, irq_prx_d;
    logic        irq_ovw_q, irq_ovw_d;
    logic        irq_rdc_q, irq_rdc_d;
    logic        busy_q, busy_d;

    logic        mem_we;
    logic [15:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic [7:0]  wr_next_page;
    logic [7:0]  rd_next_page;
    logic [7:0]  rd_word;

    assign wr_next_page = ring_next_page(wr_ptr_q[15:8], pstart, pstop);
    assign rd_next_page = ring_next_page(rd_ptr_q[15:8], pstart, pstop);
    assign rd_word      = mem[ram_addr(rd_ptr_q)];

    always_comb begin
        state_d   = state_q;
        curr_d    = curr_q;
        start_d   = start_q;
        next_d    = next_q;
        wr_ptr_d  = wr_ptr_q;
        len_d     = len_q;
        hdr_idx_d = hdr_idx_q;
        irq_prx_d = 1'b0;
        irq_ovw_d = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q;
        mem_wdata = rx_byte;

        unique case (state_q)
            ST_IDLE: begin
                if (curr_we) curr_d = curr_din;
                if (begin_rise) begin
                    start_d  = curr_q;
                    wr_ptr_d = {curr_q, 8'h04};
                    len_d    = '0;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (begin_fall) begin
                    state_d   = ST_HDR;
                    hdr_idx_d = '0;
                    // Offset 0 means the pointer already sits on the next free page.
                    next_d    = (wr_ptr_q[7:0] == 8'h00) ? wr_ptr_q[15:8] : wr_next_page;
`ifdef NE_RX_RUNT_FILTER_EN
                    if (len_q < 16'(MIN_FRAME)) state_d = ST_IDLE;
`endif
                end else if (strobe_rise) begin
                    if (len_q == MAX_LEN) begin
                        state_d = ST_DROP;
                    end else begin
                        mem_we = 1'b1;
                        len_d  = len_q + 16'd1;
                        if (wr_ptr_q[7:0] == 8'hff) begin
                            wr_ptr_d = {wr_next_page, 8'h00};
                            if (wr_next_page == bnry) begin
                                irq_ovw_d = 1'b1;
                                state_d   = ST_DROP;
                            end
                        end else begin
                            wr_ptr_d = wr_ptr_q + 16'd1;
                        end
                    end
                end
            end
            ST_HDR: begin
                mem_we    = 1'b1;
                mem_waddr = {start_q, 6'd0, hdr_idx_q};
                unique case (hdr_idx_q)
                    2'd0:    mem_wdata = HDR_STATUS_OK;
                    2'd1:    mem_wdata = next_q;
                    2'd2:    mem_wdata = len_q[7:0];
                    default: mem_wdata = len_q[15:8];
                endcase
                hdr_idx_d = hdr_idx_q + 2'd1;
                if (hdr_idx_q == 2'd3) begin
                    curr_d    = next_q;
                    irq_prx_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (begin_fall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_DATA) || (state_d == ST_HDR);
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        dma_data_d = dma_data_q;
        irq_rdc_d  = 1'b0;
        if (dma_start) begin
            rd_ptr_d = rsar;
            cnt_d    = rbcr;
        end else if (dma_rd) begin
            dma_data_d = rd_word;
            rd_ptr_d   = (rd_ptr_q[7:0] == 8'hff) ? {rd_next_page, 8'h00}
                                                  : rd_ptr_q + 16'd1;
            if (cnt_q != 16'd0) begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd1) irq_rdc_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            curr_q     <= PAGE_BASE;
            start_q    <= '0;
            next_q     <= '0;
            wr_ptr_q   <= '0;
            len_q      <= '0;
            hdr_idx_q  <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            dma_data_q <= '0;
            irq_prx_q  <= 1'b0;
            irq_ovw_q  <= 1'b0;
            irq_rdc_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            curr_q     <= curr_d;
            start_q    <= start_d;
            next_q     <= next_d;
            wr_ptr_q   <= wr_ptr_d;
            len_q      <= len_d;
            hdr_idx_q  <= hdr_idx_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            dma_data_q <= dma_data_d;
            irq_prx_q  <= irq_prx_d;
            irq_ovw_q  <= irq_ovw_d;
            irq_rdc_q  <= irq_rdc_d;
            busy_q     <= busy_d;
        end
    end

    // Ring RAM keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[ram_addr(mem_waddr)] <= mem_wdata;
    end

    assign curr     = curr_q;
    assign dma_data = dma_data_q;
    assign irq_prx  = irq_prx_q;
    assign irq_ovw  = irq_ovw_q;
    assign irq_rdc  = irq_rdc_q;
    assign busy     = busy_q;

endmodule
